// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// The JAL path is compiled in only when MIPS_CTRL_JAL_EN is defined.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_JAL     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // Datapath control word; one field per control output.
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic       iord;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal_op;
`ifdef MIPS_CTRL_JAL_EN
      logic       link;
`endif
   } ctrl_t;

   // State entered after DECODE; S_FETCH means the opcode is unsupported.
   function automatic state_t decode_target(input logic [5:0] opcode);
      state_t target;
      case (opcode)
         OP_LW, OP_SW: target = S_MEMADR;
         OP_RTYPE:     target = S_EXECUTE;
         OP_BEQ:       target = S_BRANCH;
         OP_ADDI:      target = S_ADDIEX;
         OP_J:         target = S_JUMP;
`ifdef MIPS_CTRL_JAL_EN
         OP_JAL:       target = S_JAL;
`endif
         default:      target = S_FETCH;
      endcase
      return target;
   endfunction

endpackage

// File: rtl/mips_mc_control.sv
// Moore control FSM for a multicycle MIPS; stalls in FETCH/MEMRD/MEMWR until mem_ready.
// Optional MIPS_CTRL_JAL_EN adds the JAL state and the link output.
module mips_mc_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic       branch,
   output logic       iord,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       illegal_op
`ifdef MIPS_CTRL_JAL_EN
   ,
   output logic       link
`endif
);

   state_t state;
   state_t state_next;
   ctrl_t  ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:   if (mem_ready) state_next = S_DECODE;
         S_DECODE:  state_next = decode_target(opcode);
         S_MEMADR:  state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (mem_ready) state_next = S_MEMWB;
         S_MEMWR:   if (mem_ready) state_next = S_FETCH;
         S_EXECUTE: state_next = S_ALUWB;
         S_ADDIEX:  state_next = S_ADDIWB;
         default:   state_next = S_FETCH;
      endcase
   end

   // Reset gates everything so no write enable survives into the reset cycle.
   always_comb begin
      ctrl = '0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               ctrl.mem_read  = 1'b1;
               ctrl.alu_src_b = SRCB_FOUR;
               ctrl.ir_write  = mem_ready;
               ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
               ctrl.alu_src_b  = SRCB_IMM_SH2;
               ctrl.illegal_op = (decode_target(opcode) == S_FETCH);
            end
            S_MEMADR: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
               ctrl.iord     = 1'b1;
               ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
               ctrl.mem_to_reg = 1'b1;
               ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
               ctrl.iord      = 1'b1;
               ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_B;
               ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
               ctrl.reg_dst   = 1'b1;
               ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_op    = ALU_SUB;
               ctrl.pc_src    = PC_ALUOUT;
               ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
               ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
               ctrl.pc_src   = PC_JUMP;
               ctrl.pc_write = 1'b1;
            end
`ifdef MIPS_CTRL_JAL_EN
            S_JAL: begin
               ctrl.pc_src    = PC_JUMP;
               ctrl.pc_write  = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.link      = 1'b1;
            end
`endif
            default: ctrl = '0;
         endcase
      end
   end

   assign mem_read   = ctrl.mem_read;
   assign mem_write  = ctrl.mem_write;
   assign ir_write   = ctrl.ir_write;
   assign pc_write   = ctrl.pc_write;
   assign branch     = ctrl.branch;
   assign iord       = ctrl.iord;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign reg_write  = ctrl.reg_write;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign pc_src     = ctrl.pc_src;
   assign illegal_op = ctrl.illegal_op;
`ifdef MIPS_CTRL_JAL_EN
   assign link       = ctrl.link;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle vector table plus a stalled-lw sequence.
module tb_mips_mc_control;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       mem_read, mem_write, ir_write, pc_write, branch, iord;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic       link_bit;

   mips_mc_control dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .branch     (branch),
      .iord       (iord),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_src     (pc_src),
      .illegal_op (illegal_op)
`ifdef MIPS_CTRL_JAL_EN
      ,
      .link       (link_bit)
`endif
   );

`ifndef MIPS_CTRL_JAL_EN
   assign link_bit = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef logic [17:0] out_t;

   typedef struct {
      logic       rst;
      logic [5:0] opcode;
      logic       mem_ready;
      out_t       exp;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   out_t act;
   assign act = {mem_read, mem_write, ir_write, pc_write, branch, iord, reg_dst,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                 illegal_op, link_bit};

   function automatic out_t o(input logic mr, mw, irw, pcw, br, io, rd, m2r, rw, asa,
                              input logic [1:0] asb, aop, psrc,
                              input logic ill, lnk);
      return {mr, mw, irw, pcw, br, io, rd, m2r, rw, asa, asb, aop, psrc, ill, lnk};
   endfunction

   task automatic add(input logic r, input logic [5:0] op, input logic rdy, input out_t e);
      vec_t v;
      v.rst       = r;
      v.opcode    = op;
      v.mem_ready = rdy;
      v.exp       = e;
      vecs.push_back(v);
   endtask

   out_t ZERO, FETCH_W, FETCH_R, DEC, DEC_ILL, MEMADR, MEMRD, MEMWB, MEMWR;
   out_t EXEC, ALUWB, BR, ADDIEX, ADDIWB, JMP, JAL;

   int rw_cnt, m2r_cnt, irw_cnt, rw_first, stall_bad;

   initial begin
      //                mr mw irw pcw br io rd m2r rw asa  asb    aop    psrc  ill lnk
      ZERO    = '0;
      FETCH_W = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
      FETCH_R = o(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
      DEC     = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
      DEC_ILL = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
      MEMADR  = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
      MEMRD   = o(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      MEMWB   = o(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      MEMWR   = o(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      EXEC    = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
      ALUWB   = o(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      BR      = o(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 0);
      ADDIEX  = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
      ADDIWB  = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      JMP     = o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0);
      JAL     = o(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b10, 0, 1);

      // Power-up reset, outputs forced low even with mem_ready high.
      add(1, 6'h23, 1, ZERO);
      add(1, 6'h23, 1, ZERO);
      // lw with three MEMRD stalls; mem_ready low in DECODE/MEMADR is ignored.
      add(0, 6'h23, 1, FETCH_R);
      add(0, 6'h23, 0, DEC);
      add(0, 6'h23, 0, MEMADR);
      add(0, 6'h23, 0, MEMRD);
      add(0, 6'h23, 0, MEMRD);
      add(0, 6'h23, 0, MEMRD);
      add(0, 6'h23, 1, MEMRD);
      add(0, 6'h23, 0, MEMWB);
      // sw with two FETCH stalls and one MEMWR stall.
      add(0, 6'h2B, 0, FETCH_W);
      add(0, 6'h2B, 0, FETCH_W);
      add(0, 6'h2B, 1, FETCH_R);
      add(0, 6'h2B, 1, DEC);
      add(0, 6'h2B, 1, MEMADR);
      add(0, 6'h2B, 0, MEMWR);
      add(0, 6'h2B, 1, MEMWR);
      // R-type then beq back to back.
      add(0, 6'h00, 1, FETCH_R);
      add(0, 6'h00, 1, DEC);
      add(0, 6'h00, 1, EXEC);
      add(0, 6'h00, 1, ALUWB);
      add(0, 6'h04, 1, FETCH_R);
      add(0, 6'h04, 1, DEC);
      add(0, 6'h04, 1, BR);
      // addi and j.
      add(0, 6'h08, 1, FETCH_R);
      add(0, 6'h08, 1, DEC);
      add(0, 6'h08, 1, ADDIEX);
      add(0, 6'h08, 1, ADDIWB);
      add(0, 6'h02, 1, FETCH_R);
      add(0, 6'h02, 1, DEC);
      add(0, 6'h02, 1, JMP);
      // Illegal opcode returns straight to FETCH.
      add(0, 6'h3F, 1, FETCH_R);
      add(0, 6'h3F, 1, DEC_ILL);
      // jal depends on the build.
      add(0, 6'h03, 1, FETCH_R);
`ifdef MIPS_CTRL_JAL_EN
      add(0, 6'h03, 1, DEC);
      add(0, 6'h03, 1, JAL);
`else
      add(0, 6'h03, 1, DEC_ILL);
`endif
      // Reset asserted while in MEMWB: writeback must not happen.
      add(0, 6'h23, 1, FETCH_R);
      add(0, 6'h23, 1, DEC);
      add(0, 6'h23, 1, MEMADR);
      add(0, 6'h23, 1, MEMRD);
      add(1, 6'h23, 1, ZERO);
      add(1, 6'h23, 1, ZERO);
      add(0, 6'h23, 0, FETCH_W);
      add(0, 6'h23, 1, FETCH_R);
      add(0, 6'h23, 1, DEC);

      rst       = 1'b1;
      opcode    = 6'h00;
      mem_ready = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         rst       = vecs[i].rst;
         opcode    = vecs[i].opcode;
         mem_ready = vecs[i].mem_ready;
         @(negedge clk);
         checks++;
         if (act !== vecs[i].exp) begin
            errors++;
            $display("FAIL vec[%0d] op=%h rst=%b rdy=%b got=%b exp=%b",
                     i, vecs[i].opcode, vecs[i].rst, vecs[i].mem_ready, act, vecs[i].exp);
         end
         @(posedge clk);
         #1;
      end

      // lw with MEMRD stalls on cycles 3..5: writeback lands on cycle 7 of 8.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      opcode    = 6'h23;
      rw_cnt    = 0;
      m2r_cnt   = 0;
      irw_cnt   = 0;
      rw_first  = -1;
      stall_bad = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         mem_ready = (cyc >= 3 && cyc <= 5) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (reg_write) begin
            rw_cnt++;
            if (rw_first < 0) rw_first = cyc;
         end
         if (mem_to_reg) m2r_cnt++;
         if (ir_write) irw_cnt++;
         if (cyc >= 3 && cyc <= 5 && !(mem_read && iord)) stall_bad++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (rw_first != 7) begin
         errors++;
         $display("FAIL lw_stall_wb_cycle got=%0d exp=7", rw_first);
      end
      checks++;
      if (rw_cnt != 1) begin
         errors++;
         $display("FAIL lw_stall_reg_write_count got=%0d exp=1", rw_cnt);
      end
      checks++;
      if (m2r_cnt != 1) begin
         errors++;
         $display("FAIL lw_stall_mem_to_reg_count got=%0d exp=1", m2r_cnt);
      end
      checks++;
      if (irw_cnt != 2) begin
         errors++;
         $display("FAIL lw_stall_ir_write_count got=%0d exp=2", irw_cnt);
      end
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL lw_stall_memrd_hold got=%0d bad cycles exp=0", stall_bad);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle MIPS control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives the selector inputs of the datapath's 2:1 and 4:1 multiplexers and the register/memory write enables, so it sits directly upstream of every datapath mux. Its inputs are the instruction-register opcode and a memory-ready handshake. It stalls in memory-access states until the memory responds.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- mem_ready  in  1  memory completed the current read/write this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  latch instruction register
- pc_write  out  1  unconditional PC write
- branch  out  1  PC write if ALU zero (datapath ANDs with zero)
- iord  out  1  address mux select: 0 = PC, 1 = ALU out
- reg_dst  out  1  destination mux select: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback mux select: 0 = ALU out, 1 = memory data
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct field
- pc_src  out  2  00 = ALU result, 01 = ALU out register, 10 = jump target
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- link  out  1  present only with MIPS_CTRL_JAL_EN: forces destination $31 and write data PC

## Operation
- State register is 4 bits. All outputs are decoded from the state only, except the mem_ready qualification noted below.
- Every output not listed for a state is 0.
- **FETCH:** mem_read=1, alu_src_b=01.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- **DECODE:** alu_src_b=11 (branch target precompute).
  - Next state by opcode: 0x23 or 0x2B → MEMADR; 0x00 → EXECUTE; 0x04 → BRANCH; 0x08 → ADDIEX; 0x02 → JUMP; 0x03 → JAL (only when enabled).
  - Any other opcode: illegal_op=1 and next state FETCH.
- **MEMADR:** alu_src_a=1, alu_src_b=10. Next state MEMRD for 0x23, MEMWR for 0x2B. Opcode is stable from the IR.
- **MEMRD:** iord=1, mem_read=1. Goes to MEMWB when mem_ready=1, else holds.
- **MEMWB:** mem_to_reg=1, reg_write=1 (reg_dst=0). Next state FETCH.
- **MEMWR:** iord=1, mem_write=1. Goes to FETCH when mem_ready=1, else holds with mem_write kept high.
- **EXECUTE:** alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- **ALUWB:** reg_dst=1, reg_write=1. Next state FETCH.
- **BRANCH:** alu_src_a=1, alu_op=01, pc_src=01, branch=1. Next state FETCH.
- **ADDIEX:** alu_src_a=1, alu_src_b=10. Next state ADDIWB.
- **ADDIWB:** reg_write=1 (reg_dst=0, mem_to_reg=0). Next state FETCH.
- **JUMP:** pc_src=10, pc_write=1. Next state FETCH.
- Undefined state encodings go to FETCH with all outputs 0.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- While rst=1, all outputs are forced to 0 regardless of state. The first rising edge with rst=1 loads FETCH.
- The cycle after rst deasserts is FETCH; fetch completes on the first cycle with mem_ready=1.
- Reset asserted mid-instruction:
  - Write enables drop in the same cycle as rst.
  - No partial writeback occurs.
  - The instruction restarts at FETCH.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jal 3, illegal opcode 2.
- Each wait cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. No timeout.
- pc_write and ir_write in FETCH pulse for exactly one cycle, aligned with mem_ready.

## Configuration
- Macro: MIPS_CTRL_JAL_EN.
- **Defined:**
  - Adds the JAL state: pc_src=10, pc_write=1, reg_write=1, link=1. Next state FETCH.
  - Adds the link port.
  - Opcode 0x03 decodes to JAL.
- **Undefined:**
  - No link port.
  - Opcode 0x03 is illegal: illegal_op pulses and the next state is FETCH.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL;
  - alu_op, alu_src_b and pc_src encodings.
- Single module with no sub-module: a state register plus combinational next-state and output decode.

## Test plan
- **Reset mid-cycle.** Hold rst=1 for 2 cycles while in MEMWB → all outputs 0 during reset. First cycle after release is FETCH with mem_read=1.
- **lw with stall.** opcode=0x23, mem_ready=1 except 3 low cycles in MEMRD → 8 cycles total. reg_write=1 and mem_to_reg=1 for exactly one cycle.
- **sw with fetch stall.** opcode=0x2B, mem_ready=0 for 2 cycles in FETCH → ir_write and pc_write stay low until mem_ready rises. mem_write=1 and iord=1 in MEMWR.
- **R-type then beq.** opcode=0x00 then 0x04 → EXECUTE has alu_op=10. BRANCH has alu_op=01, pc_src=01, branch=1. Back-to-back sequence takes 4+3 cycles.
- **Illegal opcode.** opcode=0x3F → illegal_op is a single pulse in DECODE, the next cycle is FETCH, and no write enable is asserted.
- **jal, both builds.** opcode=0x03 with MIPS_CTRL_JAL_EN defined → link=1, reg_write=1, pc_write=1 for one cycle. With the macro undefined → illegal_op pulses.
